pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline control and stall/redirect scheduler for the core front end. It arbitrates jump requests from the execute stage and the interrupt controller into the single redirect port of the PC register. It merges all stall sources into one encoded hold level and inserts fetch-refill bubbles after every redirect. It also sequences JTAG halt and JTAG reset, and flags a stuck system bus.

## Interface
- FLUSH_CYCLES, 2: bubble cycles after each accepted jump (0 disables).
- JTAG_RST_CYCLES, 4: cycles `jtag_reset_flag_o` stays high per reset request (≥1).
- BUS_TIMEOUT, 255: consecutive bus-hold cycles before timeout error (1..65535).
- clk  in  1  core clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- jump_flag_ex_i  in  1  execute-stage jump/branch taken.
- jump_addr_ex_i  in  32  execute-stage target.
- int_assert_i  in  1  interrupt entry/exit redirect.
- int_addr_i  in  32  interrupt target.
- hold_flag_ex_i  in  1  multi-cycle execute op busy.
- hold_flag_clint_i  in  1  interrupt controller busy.
- hold_flag_rib_i  in  1  bus arbiter has taken the bus from the core.
- jtag_halt_req_i  in  1  level: halt core while high.
- jtag_reset_req_i  in  1  request core reset.
- hold_flag_o  out  3  hold level: 0 none, 1 Hold_Pc, 2 Hold_If, 3 Hold_Id.
- jump_flag_o  out  1  redirect to PC register.
- jump_addr_o  out  32  redirect target.
- jtag_reset_flag_o  out  1  core reset to PC register and pipeline (registered).
- halted_o  out  1  core is in HALT (registered).
- bus_timeout_o  out  1  sticky bus-hold timeout error (registered).

## Operation
- FSM states RUN, HALT, RST_SEQ. Reset → RUN.
  - RUN: `jtag_reset_req_i` → RST_SEQ. Otherwise `jtag_halt_req_i` → HALT.
  - HALT: `jtag_reset_req_i` → RST_SEQ. Otherwise `!jtag_halt_req_i` → RUN.
  - RST_SEQ: reset counter loads JTAG_RST_CYCLES on entry and decrements each cycle. A new `jtag_reset_req_i` reloads it. When the counter reaches 1 and no request is pending, the FSM exits to HALT if `jtag_halt_req_i` is high, else to RUN.
- Reset request has priority over halt request.
- Redirect (combinational):
  - `jump_flag_o = (int_assert_i | jump_flag_ex_i) & state==RUN`.
  - `int_assert_i` wins over the execute stage: `jump_addr_o = int_addr_i`, else `jump_addr_ex_i`.
  - `jump_addr_o = 0` when `jump_flag_o = 0`.
  - Redirects are dropped in HALT and RST_SEQ.
- Flush counter:
  - Loads FLUSH_CYCLES on any cycle with `jump_flag_o = 1`, including a reload during an active flush.
  - Otherwise decrements, saturating at 0.
  - Cleared on RST_SEQ entry.
- Hold level: `hold_flag_o` is the maximum of all active contributions:
  - `jump_flag_o`, `hold_flag_ex_i`, `hold_flag_clint_i`, state HALT, state RST_SEQ → 3.
  - Flush counter ≠ 0 → 2.
  - `hold_flag_rib_i` → 1.
  - Nothing active → 0.
- Bus watchdog:
  - 16-bit counter increments while `hold_flag_rib_i` = 1, saturating at BUS_TIMEOUT; it clears when `hold_flag_rib_i` = 0.
  - `bus_timeout_o` sets on the edge where the counter reaches BUS_TIMEOUT and stays set until `rst`.
  - The watchdog does not affect hold or redirect.
- `halted_o = (state == HALT)`.
- `jtag_reset_flag_o = (state == RST_SEQ)`.

## Timing
- Reset values: state RUN, both counters 0, `jtag_reset_flag_o` = 0, `halted_o` = 0, `bus_timeout_o` = 0.
- While `rst` is high, `jump_flag_o`, `jump_addr_o` and `hold_flag_o` are forced to 0.
- Redirect and the level-3 hold it raises are same-cycle (0 latency), so the PC register loads the target at the next edge.
- Flush bubbles: a jump accepted in cycle k gives `hold_flag_o = 2` in cycles k+1 .. k+FLUSH_CYCLES, unless a higher contribution is active.
- JTAG reset: request sampled at edge e. `jtag_reset_flag_o` = 1 for exactly JTAG_RST_CYCLES cycles after e, then falls. Back-to-back requests stretch the pulse.
- Halt: `jtag_halt_req_i` sampled at edge e. `halted_o` and the level-3 hold begin after e. Deassertion returns to RUN one edge later.
- Simultaneous `int_assert_i` and `jump_flag_ex_i`: the interrupt target is used, and a single flush follows.
- A jump in the same cycle as a reset or halt request is still honoured if the state is RUN in that cycle.

## Test plan
- Reset: hold `rst` 3 cycles with all inputs toggling → every output 0; state RUN.
- Jump: `jump_flag_ex_i` = 1, `jump_addr_ex_i` = 0x0000_0100 for 1 cycle (FLUSH_CYCLES = 2) → same cycle `jump_flag_o` = 1, addr 0x100, hold = 3; next 2 cycles hold = 2; then hold = 0.
- Priority: `int_assert_i` and `jump_flag_ex_i` together (addrs 0x200 / 0x100), plus `hold_flag_rib_i` = 1 → `jump_addr_o` = 0x200, hold = 3. Next cycles hold = 2 (flush beats rib).
- JTAG reset: pulse `jtag_reset_req_i` 1 cycle (JTAG_RST_CYCLES = 4) → `jtag_reset_flag_o` high exactly 4 cycles, hold = 3. A concurrent `jump_flag_ex_i` → `jump_flag_o` = 0. Re-pulse at cycle 2 → flag high 4 cycles from the re-pulse.
- Halt: `jtag_halt_req_i` high 10 cycles with `int_assert_i` = 1 → `halted_o` = 1, hold = 3, `jump_flag_o` = 0 throughout. After deassert, RUN next cycle and the interrupt redirect is accepted.
- Watchdog (BUS_TIMEOUT = 8): `hold_flag_rib_i` high 7 cycles then low → `bus_timeout_o` stays 0. High 8 cycles → `bus_timeout_o` = 1 and remains 1 after rib drops, until `rst`.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_if
// Description : Redirect, hold and JTAG control bundle between the front-end
//               sources and the pipeline control scheduler.
// Revision    : 1.0
// ============================================================================
interface pipe_ctrl_if;
    logic        jump_flag_ex_i;
    logic [31:0] jump_addr_ex_i;
    logic        int_assert_i;
    logic [31:0] int_addr_i;
    logic        hold_flag_ex_i;
    logic        hold_flag_clint_i;
    logic        hold_flag_rib_i;
    logic        jtag_halt_req_i;
    logic        jtag_reset_req_i;
    logic [2:0]  hold_flag_o;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic        jtag_reset_flag_o;
    logic        halted_o;
    logic        bus_timeout_o;

    modport master (
        output jump_flag_ex_i, jump_addr_ex_i, int_assert_i, int_addr_i,
               hold_flag_ex_i, hold_flag_clint_i, hold_flag_rib_i,
               jtag_halt_req_i, jtag_reset_req_i,
        input  hold_flag_o, jump_flag_o, jump_addr_o,
               jtag_reset_flag_o, halted_o, bus_timeout_o
    );

    modport slave (
        input  jump_flag_ex_i, jump_addr_ex_i, int_assert_i, int_addr_i,
               hold_flag_ex_i, hold_flag_clint_i, hold_flag_rib_i,
               jtag_halt_req_i, jtag_reset_req_i,
        output hold_flag_o, jump_flag_o, jump_addr_o,
               jtag_reset_flag_o, halted_o, bus_timeout_o
    );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Front-end stall/redirect scheduler with flush bubbles, JTAG
//               halt/reset sequencing and a sticky bus-hold watchdog.
// Revision    : 1.0
// ============================================================================
module pipe_ctrl #(
    parameter int FLUSH_CYCLES    = 2,
    parameter int JTAG_RST_CYCLES = 4,
    parameter int BUS_TIMEOUT     = 255
) (
    input  wire logic  clk,
    input  wire logic  rst,
    pipe_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HALT    = 2'd1,
        RST_SEQ = 2'd2
    } state_t;

    localparam int              c_flush_w   = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam int              c_rst_w     = $clog2(JTAG_RST_CYCLES + 1);
    localparam logic [c_flush_w-1:0] c_flush_load = c_flush_w'(FLUSH_CYCLES);
    localparam logic [c_flush_w-1:0] c_flush_one  = c_flush_w'(1);
    localparam logic [c_rst_w-1:0]   c_rst_load   = c_rst_w'(JTAG_RST_CYCLES);
    localparam logic [c_rst_w-1:0]   c_rst_one    = c_rst_w'(1);
    localparam logic [15:0]          c_bus_to     = 16'(BUS_TIMEOUT);

    state_t               state_q, state_d;
    logic [c_flush_w-1:0] flush_cnt_q, flush_cnt_d;
    logic [c_rst_w-1:0]   rst_cnt_q, rst_cnt_d;
    logic [15:0]          wd_cnt_q, wd_cnt_d;
    logic                 bus_timeout_q, bus_timeout_d;
    logic                 halted_q, halted_d;
    logic                 jtag_rst_flag_q, jtag_rst_flag_d;

    logic                 w_jump;
    logic [31:0]          w_jump_addr;
    logic [2:0]           w_hold;

    // Redirect and hold are combinational so the PC loads the target next edge.
    always_comb begin
        w_jump      = 1'b0;
        w_jump_addr = 32'h0;
        if (!rst && state_q == RUN && (bus.int_assert_i || bus.jump_flag_ex_i)) begin
            w_jump      = 1'b1;
            w_jump_addr = bus.int_assert_i ? bus.int_addr_i : bus.jump_addr_ex_i;
        end

        w_hold = 3'd0;
        if (bus.hold_flag_rib_i) begin
            w_hold = 3'd1;
        end
        if (flush_cnt_q != '0) begin
            w_hold = 3'd2;
        end
        if (w_jump || bus.hold_flag_ex_i || bus.hold_flag_clint_i || state_q != RUN) begin
            w_hold = 3'd3;
        end
        if (rst) begin
            w_hold = 3'd0;
        end
    end

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        case (state_q)
            RUN: begin
                if (bus.jtag_reset_req_i) begin
                    state_d   = RST_SEQ;
                    rst_cnt_d = c_rst_load;
                end else if (bus.jtag_halt_req_i) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                if (bus.jtag_reset_req_i) begin
                    state_d   = RST_SEQ;
                    rst_cnt_d = c_rst_load;
                end else if (!bus.jtag_halt_req_i) begin
                    state_d = RUN;
                end
            end
            RST_SEQ: begin
                if (bus.jtag_reset_req_i) begin
                    rst_cnt_d = c_rst_load;
                end else if (rst_cnt_q <= c_rst_one) begin
                    rst_cnt_d = '0;
                    state_d   = bus.jtag_halt_req_i ? HALT : RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q - c_rst_one;
                end
            end
            default: begin
                state_d   = RUN;
                rst_cnt_d = '0;
            end
        endcase

        // Entering the reset sequence discards any pending refill bubbles.
        flush_cnt_d = flush_cnt_q;
        if (state_q != RST_SEQ && state_d == RST_SEQ) begin
            flush_cnt_d = '0;
        end else if (w_jump) begin
            flush_cnt_d = c_flush_load;
        end else if (flush_cnt_q != '0) begin
            flush_cnt_d = flush_cnt_q - c_flush_one;
        end

        wd_cnt_d = 16'h0;
        if (bus.hold_flag_rib_i) begin
            wd_cnt_d = (wd_cnt_q < c_bus_to) ? wd_cnt_q + 16'h1 : wd_cnt_q;
        end
        bus_timeout_d = bus_timeout_q || (bus.hold_flag_rib_i && wd_cnt_d == c_bus_to);

        halted_d        = (state_d == HALT);
        jtag_rst_flag_d = (state_d == RST_SEQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= RUN;
            flush_cnt_q     <= '0;
            rst_cnt_q       <= '0;
            wd_cnt_q        <= 16'h0;
            bus_timeout_q   <= 1'b0;
            halted_q        <= 1'b0;
            jtag_rst_flag_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            flush_cnt_q     <= flush_cnt_d;
            rst_cnt_q       <= rst_cnt_d;
            wd_cnt_q        <= wd_cnt_d;
            bus_timeout_q   <= bus_timeout_d;
            halted_q        <= halted_d;
            jtag_rst_flag_q <= jtag_rst_flag_d;
        end
    end

    assign bus.jump_flag_o       = w_jump;
    assign bus.jump_addr_o       = w_jump_addr;
    assign bus.hold_flag_o       = w_hold;
    assign bus.jtag_reset_flag_o = jtag_rst_flag_q;
    assign bus.halted_o          = halted_q;
    assign bus.bus_timeout_o     = bus_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Cycle-by-cycle vector bench for pipe_ctrl with an expected-
//               result queue (FLUSH=2, JTAG_RST=4, BUS_TIMEOUT=8).
// Revision    : 1.0
// ============================================================================
module tb_pipe_ctrl;

    typedef struct {
        logic        rst;
        logic        jex;
        logic [31:0] jaddr;
        logic        ia;
        logic [31:0] iaddr;
        logic        hex;
        logic        hcl;
        logic        rib;
        logic        halt;
        logic        jrst;
        logic [2:0]  e_hold;
        logic        e_jf;
        logic [31:0] e_ja;
        logic        e_rf;
        logic        e_hl;
        logic        e_to;
        logic        chk_reg;
    } vec_t;

    typedef struct {
        logic [2:0]  hold;
        logic        jf;
        logic [31:0] ja;
        logic        rf;
        logic        hl;
        logic        to;
        logic        chk_reg;
    } exp_t;

    logic   clk;
    logic   rst;
    int     n_cmp;
    int     n_bad;
    int     cyc;
    vec_t   tbl[$];
    exp_t   exp_q[$];

    pipe_ctrl_if bus_if ();

    pipe_ctrl #(
        .FLUSH_CYCLES    (2),
        .JTAG_RST_CYCLES (4),
        .BUS_TIMEOUT     (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void add(
        input logic r, input logic jex, input logic [31:0] ja,
        input logic ia, input logic [31:0] iad,
        input logic hex, input logic hcl, input logic rib,
        input logic hlt, input logic jr,
        input logic [2:0] eh, input logic ejf, input logic [31:0] eja,
        input logic erf, input logic ehl, input logic eto);
        vec_t v;
        v.rst = r; v.jex = jex; v.jaddr = ja; v.ia = ia; v.iaddr = iad;
        v.hex = hex; v.hcl = hcl; v.rib = rib; v.halt = hlt; v.jrst = jr;
        v.e_hold = eh; v.e_jf = ejf; v.e_ja = eja;
        v.e_rf = erf; v.e_hl = ehl; v.e_to = eto; v.chk_reg = 1'b1;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        exp_t e;
        @(negedge clk);
        rst                     = v.rst;
        bus_if.jump_flag_ex_i   = v.jex;
        bus_if.jump_addr_ex_i   = v.jaddr;
        bus_if.int_assert_i     = v.ia;
        bus_if.int_addr_i       = v.iaddr;
        bus_if.hold_flag_ex_i   = v.hex;
        bus_if.hold_flag_clint_i = v.hcl;
        bus_if.hold_flag_rib_i  = v.rib;
        bus_if.jtag_halt_req_i  = v.halt;
        bus_if.jtag_reset_req_i = v.jrst;
        exp_q.push_back('{v.e_hold, v.e_jf, v.e_ja, v.e_rf, v.e_hl, v.e_to, v.chk_reg});
        #2;
        e = exp_q.pop_front();
        chk("hold_flag_o", 32'(bus_if.hold_flag_o), 32'(e.hold));
        chk("jump_flag_o", 32'(bus_if.jump_flag_o), 32'(e.jf));
        chk("jump_addr_o", bus_if.jump_addr_o, e.ja);
        if (e.chk_reg) begin
            chk("jtag_reset_flag_o", 32'(bus_if.jtag_reset_flag_o), 32'(e.rf));
            chk("halted_o", 32'(bus_if.halted_o), 32'(e.hl));
            chk("bus_timeout_o", 32'(bus_if.bus_timeout_o), 32'(e.to));
        end
        cyc++;
    endtask

    initial begin
        vec_t v;
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        rst   = 1'b1;
        bus_if.jump_flag_ex_i    = 1'b0;
        bus_if.jump_addr_ex_i    = 32'h0;
        bus_if.int_assert_i      = 1'b0;
        bus_if.int_addr_i        = 32'h0;
        bus_if.hold_flag_ex_i    = 1'b0;
        bus_if.hold_flag_clint_i = 1'b0;
        bus_if.hold_flag_rib_i   = 1'b0;
        bus_if.jtag_halt_req_i   = 1'b0;
        bus_if.jtag_reset_req_i  = 1'b0;

        // Reset with toggling inputs; flops are unknown until the first edge.
        for (int i = 0; i < 3; i++) begin
            v = '{1'b1, 1'($urandom), $urandom, 1'($urandom), $urandom,
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  3'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, (i > 0)};
            step(v);
        end

        //  r jex jaddr      ia iaddr      hex hcl rib hlt jr  hold jf ja         rf hl to
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 0, 0, 0,  3'd0, 0, 32'h0,     0, 0, 0);
        add(0, 1, 32'h100,   0, 32'h0,     0, 0, 0, 0, 0,  3'd3, 1, 32'h100,   0, 0, 0);
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 0, 0, 0,  3'd2, 0, 32'h0,     0, 0, 0);
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 0, 0, 0,  3'd2, 0, 32'h0,     0, 0, 0);
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 0, 0, 0,  3'd0, 0, 32'h0,     0, 0, 0);
        add(0, 1, 32'h100,   1, 32'h200,   0, 0, 1, 0, 0,  3'd3, 1, 32'h200,   0, 0, 0);
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 1, 0, 0,  3'd2, 0, 32'h0,     0, 0, 0);
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 1, 0, 0,  3'd2, 0, 32'h0,     0, 0, 0);
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 1, 0, 0,  3'd1, 0, 32'h0,     0, 0, 0);
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 0, 0, 0,  3'd0, 0, 32'h0,     0, 0, 0);
        add(0, 0, 32'h0,     0, 32'h0,     1, 0, 0, 0, 0,  3'd3, 0, 32'h0,     0, 0, 0);
        add(0, 0, 32'h0,     0, 32'h0,     0, 1, 0, 0, 0,  3'd3, 0, 32'h0,     0, 0, 0);
        add(0, 0, 32'h100,   1, 32'h300,   0, 0, 0, 0, 0,  3'd3, 1, 32'h300,   0, 0, 0);
        add(0, 1, 32'h140,   0, 32'h0,     0, 0, 0, 0, 0,  3'd3, 1, 32'h140,   0, 0, 0);
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 0, 0, 0,  3'd2, 0, 32'h0,     0, 0, 0);
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 0, 0, 0,  3'd2, 0, 32'h0,     0, 0, 0);
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 0, 0, 0,  3'd0, 0, 32'h0,     0, 0, 0);
        // JTAG reset with a same-cycle jump, then a re-pulse during the sequence
        add(0, 1, 32'h180,   0, 32'h0,     0, 0, 0, 0, 1,  3'd3, 1, 32'h180,   0, 0, 0);
        add(0, 1, 32'h1c0,   0, 32'h0,     0, 0, 0, 0, 0,  3'd3, 0, 32'h0,     1, 0, 0);
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 0, 0, 1,  3'd3, 0, 32'h0,     1, 0, 0);
        for (int i = 0; i < 4; i++)
            add(0, 0, 32'h0, 0, 32'h0,     0, 0, 0, 0, 0,  3'd3, 0, 32'h0,     1, 0, 0);
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 0, 0, 0,  3'd0, 0, 32'h0,     0, 0, 0);
        // Single pulse: exactly four cycles of reset flag
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 0, 0, 1,  3'd0, 0, 32'h0,     0, 0, 0);
        for (int i = 0; i < 4; i++)
            add(0, 0, 32'h0, 0, 32'h0,     0, 0, 0, 0, 0,  3'd3, 0, 32'h0,     1, 0, 0);
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 0, 0, 0,  3'd0, 0, 32'h0,     0, 0, 0);
        // Halt for 10 cycles with an interrupt pending
        add(0, 0, 32'h0,     1, 32'h400,   0, 0, 0, 1, 0,  3'd3, 1, 32'h400,   0, 0, 0);
        for (int i = 0; i < 9; i++)
            add(0, 0, 32'h0, 1, 32'h400,   0, 0, 0, 1, 0,  3'd3, 0, 32'h0,     0, 1, 0);
        add(0, 0, 32'h0,     1, 32'h400,   0, 0, 0, 0, 0,  3'd3, 0, 32'h0,     0, 1, 0);
        add(0, 0, 32'h0,     1, 32'h400,   0, 0, 0, 0, 0,  3'd3, 1, 32'h400,   0, 0, 0);
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 0, 0, 0,  3'd2, 0, 32'h0,     0, 0, 0);
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 0, 0, 0,  3'd2, 0, 32'h0,     0, 0, 0);
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 0, 0, 0,  3'd0, 0, 32'h0,     0, 0, 0);
        // Reset beats halt, then the sequence exits into HALT
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 0, 1, 1,  3'd0, 0, 32'h0,     0, 0, 0);
        for (int i = 0; i < 4; i++)
            add(0, 0, 32'h0, 0, 32'h0,     0, 0, 0, 1, 0,  3'd3, 0, 32'h0,     1, 0, 0);
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 0, 1, 0,  3'd3, 0, 32'h0,     0, 1, 0);
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 0, 0, 0,  3'd3, 0, 32'h0,     0, 1, 0);
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 0, 0, 0,  3'd0, 0, 32'h0,     0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end
        tbl.delete();

        // Watchdog: 7 held cycles stay below the limit, 8 trip it for good
        for (int i = 0; i < 7; i++)
            add(0, 0, 32'h0, 0, 32'h0,     0, 0, 1, 0, 0,  3'd1, 0, 32'h0,     0, 0, 0);
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 0, 0, 0,  3'd0, 0, 32'h0,     0, 0, 0);
        for (int i = 0; i < 8; i++)
            add(0, 0, 32'h0, 0, 32'h0,     0, 0, 1, 0, 0,  3'd1, 0, 32'h0,     0, 0, 0);
        for (int i = 0; i < 3; i++)
            add(0, 0, 32'h0, 0, 32'h0,     0, 0, 0, 0, 0,  3'd0, 0, 32'h0,     0, 0, 1);
        // rst forces combinational outputs low and finally clears the sticky error
        add(1, 1, 32'h500,   1, 32'h510,   1, 1, 1, 0, 0,  3'd0, 0, 32'h0,     0, 0, 1);
        add(1, 0, 32'h0,     0, 32'h0,     0, 0, 0, 0, 0,  3'd0, 0, 32'h0,     0, 0, 0);
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 0, 0, 0,  3'd0, 0, 32'h0,     0, 0, 0);
        add(0, 1, 32'h600,   0, 32'h0,     0, 0, 0, 0, 0,  3'd3, 1, 32'h600,   0, 0, 0);
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 0, 0, 0,  3'd2, 0, 32'h0,     0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
